// File: rtl/cci_mpf_shim_req_limiter_pkg.sv
// Shared types for the CCI-MPF request limiter shim: count types, drain FSM encoding, Rx structs.
// Optional simulation logging in the top is enabled with CCI_MPF_REQ_LIMITER_LOG_EN.
package cci_mpf_shim_pkg;

  localparam int DEF_MAX_RD_INFLIGHT = 128;
  localparam int DEF_MAX_WR_INFLIGHT = 128;
  localparam int DEF_STAT_WIDTH      = 32;
  localparam int HDR_W               = 64;
  localparam int DATA_W              = 512;

  typedef logic [$clog2(DEF_MAX_RD_INFLIGHT+1)-1:0] t_rd_cnt;
  typedef logic [$clog2(DEF_MAX_WR_INFLIGHT+1)-1:0] t_wr_cnt;
  typedef logic [DEF_STAT_WIDTH-1:0]                t_stat_cnt;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAINING = 2'd1,
    DRAINED  = 2'd2
  } t_drain_state;

  typedef struct packed {
    logic [HDR_W-1:0]  hdr;
    logic [DATA_W-1:0] data;
    logic              rdValid;
    logic              wrValid;
  } t_c0_rx;

  typedef struct packed {
    logic [HDR_W-1:0] hdr;
    logic             wrValid;
  } t_c1_rx;

  // Clamp cur+delta into [0, max_val].
  function automatic int satAdd(input int cur, input int delta, input int max_val);
    int s;
    s = cur + delta;
    if (s > max_val) return max_val;
    if (s < 0)       return 0;
    return s;
  endfunction

endpackage

// File: rtl/cci_mpf_shim_req_limiter_if.sv
// CCI-MPF request/response bundle. to_afu/slave face the AFU, to_qlp/master face the QLP.
interface cci_mpf_if;
  import cci_mpf_shim_pkg::*;

  logic              reset_n;
  logic [HDR_W-1:0]  c0TxHdr;
  logic              c0TxRdValid;
  logic [HDR_W-1:0]  c1TxHdr;
  logic [DATA_W-1:0] c1TxData;
  logic              c1TxWrValid;
  logic              c1TxIrValid;
  logic              c0TxAlmFull;
  logic              c1TxAlmFull;
  t_c0_rx            c0Rx;
  t_c1_rx            c1Rx;

  modport to_afu (
    input  c0TxHdr, c0TxRdValid, c1TxHdr, c1TxData, c1TxWrValid, c1TxIrValid,
    output reset_n, c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx
  );

  modport to_qlp (
    output c0TxHdr, c0TxRdValid, c1TxHdr, c1TxData, c1TxWrValid, c1TxIrValid,
    input  reset_n, c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx
  );

  modport slave (
    input  c0TxHdr, c0TxRdValid, c1TxHdr, c1TxData, c1TxWrValid, c1TxIrValid,
    output reset_n, c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx
  );

  modport master (
    output c0TxHdr, c0TxRdValid, c1TxHdr, c1TxData, c1TxWrValid, c1TxIrValid,
    input  reset_n, c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx
  );

endinterface

// File: rtl/cci_mpf_shim_req_limiter_inflight_cnt.sv
// Saturating in-flight counter: applies a signed per-cycle delta, holds at 0/MAX and
// flags the cycle where the unclamped result would have left that range.
module cci_mpf_inflight_cnt
  import cci_mpf_shim_pkg::*;
#(
  parameter int MAX = 128,
  parameter int CW  = $clog2(MAX+1)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic signed [CW+1:0] delta_i,
  output logic [CW-1:0]       cnt_o,
  output logic                ovf_o,
  output logic                unf_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  int            sum;

  always_comb begin
    sum   = int'(cnt_q) + int'(delta_i);
    ovf_o = (sum > MAX);
    unf_o = (sum < 0);
    cnt_d = CW'(satAdd(int'(cnt_q), int'(delta_i), MAX));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cci_mpf_shim_req_limiter.sv
// In-flight request limiter between AFU and QLP: zero-latency pass-through, per-channel almost-full
// forcing, drain handshake, sticky error flags and statistics. Define CCI_MPF_REQ_LIMITER_LOG_EN for a sim event log.
//
//  state    | meaning
//  IDLE     | normal traffic, no forced almost-full from draining
//  DRAINING | drain requested, almost-full forced, waiting for both counts to reach 0
//  DRAINED  | both counts 0 while drain held, drain_done asserted
module cci_mpf_shim_req_limiter
  import cci_mpf_shim_pkg::*;
#(
  parameter int MAX_RD_INFLIGHT = 128,
  parameter int MAX_WR_INFLIGHT = 128,
  parameter int ALM_FULL_SLACK  = 4,
  parameter int STAT_WIDTH      = 32,
  localparam int CW_RD          = $clog2(MAX_RD_INFLIGHT+1),
  localparam int CW_WR          = $clog2(MAX_WR_INFLIGHT+1)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  cci_mpf_if.to_afu             afu,
  cci_mpf_if.to_qlp             qlp,
  input  logic                  drain_req_i,
  output logic                  drain_done_o,
  output logic [CW_RD-1:0]      rd_inflight_o,
  output logic [CW_WR-1:0]      wr_inflight_o,
  output logic                  err_overflow_o,
  output logic                  err_underflow_o,
  output logic [STAT_WIDTH-1:0] stat_rd_reqs_o,
  output logic [STAT_WIDTH-1:0] stat_wr_reqs_o,
  output logic [CW_RD-1:0]      stat_rd_peak_o
);

  localparam logic signed [CW_RD+1:0] RD_ONE    = (CW_RD+2)'(1);
  localparam logic signed [CW_WR+1:0] WR_ONE    = (CW_WR+2)'(1);
  localparam logic [CW_RD-1:0]        RD_THRESH = CW_RD'(MAX_RD_INFLIGHT - ALM_FULL_SLACK);
  localparam logic [CW_WR-1:0]        WR_THRESH = CW_WR'(MAX_WR_INFLIGHT - ALM_FULL_SLACK);

  logic [CW_RD-1:0]        rd_cnt;
  logic [CW_WR-1:0]        wr_cnt;
  logic signed [CW_RD+1:0] rd_delta;
  logic signed [CW_WR+1:0] wr_delta;
  logic                    rd_ovf, rd_unf, wr_ovf, wr_unf;
  t_drain_state            state_q, state_d;
  logic                    blocking, drain_done;
  logic                    err_ovf_q, err_unf_q;
  logic [STAT_WIDTH-1:0]   stat_rd_q, stat_wr_q;
  logic [CW_RD-1:0]        peak_q;

  assign qlp.c0TxHdr     = afu.c0TxHdr;
  assign qlp.c0TxRdValid = afu.c0TxRdValid;
  assign qlp.c1TxHdr     = afu.c1TxHdr;
  assign qlp.c1TxData    = afu.c1TxData;
  assign qlp.c1TxWrValid = afu.c1TxWrValid;
  assign qlp.c1TxIrValid = afu.c1TxIrValid;
  assign afu.c0Rx        = qlp.c0Rx;
  assign afu.c1Rx        = qlp.c1Rx;
  assign afu.reset_n     = qlp.reset_n;

  // Interrupts are forwarded but never occupy an in-flight slot.
  always_comb begin
    rd_delta = '0;
    if (qlp.c0TxRdValid)  rd_delta = rd_delta + RD_ONE;
    if (qlp.c0Rx.rdValid) rd_delta = rd_delta - RD_ONE;
    wr_delta = '0;
    if (qlp.c1TxWrValid)  wr_delta = wr_delta + WR_ONE;
    if (qlp.c0Rx.wrValid) wr_delta = wr_delta - WR_ONE;
    if (qlp.c1Rx.wrValid) wr_delta = wr_delta - WR_ONE;
  end

  cci_mpf_inflight_cnt #(.MAX(MAX_RD_INFLIGHT), .CW(CW_RD)) u_rd_cnt (
    .clk_i   (clk_i),
    .rst_n_i (reset_n_i),
    .delta_i (rd_delta),
    .cnt_o   (rd_cnt),
    .ovf_o   (rd_ovf),
    .unf_o   (rd_unf)
  );

  cci_mpf_inflight_cnt #(.MAX(MAX_WR_INFLIGHT), .CW(CW_WR)) u_wr_cnt (
    .clk_i   (clk_i),
    .rst_n_i (reset_n_i),
    .delta_i (wr_delta),
    .cnt_o   (wr_cnt),
    .ovf_o   (wr_ovf),
    .unf_o   (wr_unf)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      stat_rd_q <= '0;
      stat_wr_q <= '0;
      peak_q    <= '0;
    end else begin
      err_ovf_q <= err_ovf_q | rd_ovf | wr_ovf;
      err_unf_q <= err_unf_q | rd_unf | wr_unf;
      if (qlp.c0TxRdValid) stat_rd_q <= stat_rd_q + STAT_WIDTH'(1);
      if (qlp.c1TxWrValid) stat_wr_q <= stat_wr_q + STAT_WIDTH'(1);
      if (rd_cnt > peak_q) peak_q <= rd_cnt;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (drain_req_i) state_d = DRAINING;
      DRAINING: begin
        if (!drain_req_i)                        state_d = IDLE;
        else if (rd_cnt == '0 && wr_cnt == '0)   state_d = DRAINED;
      end
      DRAINED:  if (!drain_req_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    blocking   = (state_q != IDLE);
    drain_done = (state_q == DRAINED);
  end

  assign afu.c0TxAlmFull = qlp.c0TxAlmFull | (rd_cnt >= RD_THRESH) | blocking;
  assign afu.c1TxAlmFull = qlp.c1TxAlmFull | (wr_cnt >= WR_THRESH) | blocking;

  assign drain_done_o    = drain_done;
  assign rd_inflight_o   = rd_cnt;
  assign wr_inflight_o   = wr_cnt;
  assign err_overflow_o  = err_ovf_q;
  assign err_underflow_o = err_unf_q;
  assign stat_rd_reqs_o  = stat_rd_q;
  assign stat_wr_reqs_o  = stat_wr_q;
  assign stat_rd_peak_o  = peak_q;

`ifdef CCI_MPF_REQ_LIMITER_LOG_EN
  logic         c0_af_prev, c1_af_prev, ovf_prev, unf_prev;
  t_drain_state state_prev;

  initial begin
    c0_af_prev = 1'b0;
    c1_af_prev = 1'b0;
    ovf_prev   = 1'b0;
    unf_prev   = 1'b0;
    state_prev = IDLE;
  end

  always @(posedge clk_i) begin
    if (afu.c0TxAlmFull != c0_af_prev)
      $display("%m\t%0t\tc0_alm_full_%0b\t%0d\t%0d", $time, afu.c0TxAlmFull, rd_cnt, wr_cnt);
    if (afu.c1TxAlmFull != c1_af_prev)
      $display("%m\t%0t\tc1_alm_full_%0b\t%0d\t%0d", $time, afu.c1TxAlmFull, rd_cnt, wr_cnt);
    if (state_q != state_prev)
      $display("%m\t%0t\tstate_%s\t%0d\t%0d", $time, state_q.name(), rd_cnt, wr_cnt);
    if (err_ovf_q && !ovf_prev)
      $display("%m\t%0t\terr_overflow\t%0d\t%0d", $time, rd_cnt, wr_cnt);
    if (err_unf_q && !unf_prev)
      $display("%m\t%0t\terr_underflow\t%0d\t%0d", $time, rd_cnt, wr_cnt);
    c0_af_prev = afu.c0TxAlmFull;
    c1_af_prev = afu.c1TxAlmFull;
    state_prev = state_q;
    ovf_prev   = err_ovf_q;
    unf_prev   = err_unf_q;
  end
`endif

endmodule

// File: tb/tb_cci_mpf_shim_req_limiter.sv
// Directed bench for the request limiter: limits, same-cycle events, error flags, drain and resets.
module tb_cci_mpf_shim_req_limiter;

  logic        clk_i;
  logic        reset_n_i;
  logic        drain_req_i;
  logic        drain_done_o;
  logic [7:0]  rd_inflight_o;
  logic [7:0]  wr_inflight_o;
  logic        err_overflow_o;
  logic        err_underflow_o;
  logic [31:0] stat_rd_reqs_o;
  logic [31:0] stat_wr_reqs_o;
  logic [7:0]  stat_rd_peak_o;

  int n_chk  = 0;
  int n_pass = 0;

  cci_mpf_if afu_if ();
  cci_mpf_if qlp_if ();

  cci_mpf_shim_req_limiter dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .afu             (afu_if),
    .qlp             (qlp_if),
    .drain_req_i     (drain_req_i),
    .drain_done_o    (drain_done_o),
    .rd_inflight_o   (rd_inflight_o),
    .wr_inflight_o   (wr_inflight_o),
    .err_overflow_o  (err_overflow_o),
    .err_underflow_o (err_underflow_o),
    .stat_rd_reqs_o  (stat_rd_reqs_o),
    .stat_wr_reqs_o  (stat_wr_reqs_o),
    .stat_rd_peak_o  (stat_rd_peak_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_rd(input int n);
    for (int i = 0; i < n; i++) begin
      afu_if.c0TxRdValid = 1'b1;
      tick();
    end
    afu_if.c0TxRdValid = 1'b0;
  endtask

  task automatic rsp_rd(input int n);
    for (int i = 0; i < n; i++) begin
      qlp_if.c0Rx.rdValid = 1'b1;
      tick();
    end
    qlp_if.c0Rx.rdValid = 1'b0;
  endtask

  initial begin
    reset_n_i   = 1'b1;
    drain_req_i = 1'b0;
    afu_if.c0TxHdr     = 64'h0;
    afu_if.c0TxRdValid = 1'b0;
    afu_if.c1TxHdr     = 64'h0;
    afu_if.c1TxData    = '0;
    afu_if.c1TxWrValid = 1'b0;
    afu_if.c1TxIrValid = 1'b0;
    qlp_if.reset_n     = 1'b1;
    qlp_if.c0TxAlmFull = 1'b0;
    qlp_if.c1TxAlmFull = 1'b0;
    qlp_if.c0Rx        = '0;
    qlp_if.c1Rx        = '0;
    #1 reset_n_i = 1'b0;
    tick();
    tick();

    // reset state
    check_eq("rst_rd_inflight", rd_inflight_o, 0);
    check_eq("rst_wr_inflight", wr_inflight_o, 0);
    check_eq("rst_err_ovf", err_overflow_o, 0);
    check_eq("rst_err_unf", err_underflow_o, 0);
    check_eq("rst_stat_rd", stat_rd_reqs_o, 0);
    check_eq("rst_stat_wr", stat_wr_reqs_o, 0);
    check_eq("rst_peak", stat_rd_peak_o, 0);
    check_eq("rst_drain_done", drain_done_o, 0);
    check_eq("rst_c0_af_follow", afu_if.c0TxAlmFull, 0);
    qlp_if.c0TxAlmFull = 1'b1;
    qlp_if.c1TxAlmFull = 1'b1;
    #1;
    check_eq("rst_c0_af_pass", afu_if.c0TxAlmFull, 1);
    check_eq("rst_c1_af_pass", afu_if.c1TxAlmFull, 1);
    qlp_if.c0TxAlmFull = 1'b0;
    qlp_if.c1TxAlmFull = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    tick();

    // read limit: threshold 124
    afu_if.c0TxHdr = 64'hDEAD_BEEF_0123_4567;
    #1;
    check_eq("hdr_pass", qlp_if.c0TxHdr, 64'hDEAD_BEEF_0123_4567);
    issue_rd(123);
    check_eq("rd_123", rd_inflight_o, 123);
    check_eq("af_below_thresh", afu_if.c0TxAlmFull, 0);
    issue_rd(1);
    check_eq("rd_124", rd_inflight_o, 124);
    check_eq("af_at_thresh", afu_if.c0TxAlmFull, 1);
    check_eq("c1_af_indep", afu_if.c1TxAlmFull, 0);
    check_eq("stat_rd_124", stat_rd_reqs_o, 124);
    qlp_if.c0Rx.rdValid = 1'b1;
    #1;
    check_eq("rx_pass", afu_if.c0Rx.rdValid, 1);
    tick();
    qlp_if.c0Rx.rdValid = 1'b0;
    check_eq("rd_after_rsp", rd_inflight_o, 123);
    check_eq("af_drop", afu_if.c0TxAlmFull, 0);
    check_eq("peak_124", stat_rd_peak_o, 124);

    // same-cycle read request and response
    afu_if.c0TxRdValid  = 1'b1;
    qlp_if.c0Rx.rdValid = 1'b1;
    tick();
    afu_if.c0TxRdValid  = 1'b0;
    qlp_if.c0Rx.rdValid = 1'b0;
    check_eq("rd_same_cycle", rd_inflight_o, 123);
    check_eq("stat_rd_125", stat_rd_reqs_o, 125);
    rsp_rd(123);
    check_eq("rd_drained", rd_inflight_o, 0);

    // writes, with both response channels in the same cycle as a request
    for (int i = 0; i < 5; i++) begin
      afu_if.c1TxWrValid = 1'b1;
      tick();
    end
    check_eq("wr_5", wr_inflight_o, 5);
    qlp_if.c0Rx.wrValid = 1'b1;
    qlp_if.c1Rx.wrValid = 1'b1;
    tick();
    afu_if.c1TxWrValid  = 1'b0;
    qlp_if.c0Rx.wrValid = 1'b0;
    qlp_if.c1Rx.wrValid = 1'b0;
    check_eq("wr_net_minus1", wr_inflight_o, 4);
    afu_if.c1TxIrValid = 1'b1;
    #1;
    check_eq("ir_pass", qlp_if.c1TxIrValid, 1);
    tick();
    afu_if.c1TxIrValid = 1'b0;
    check_eq("ir_not_counted", wr_inflight_o, 4);
    check_eq("stat_wr_6", stat_wr_reqs_o, 6);
    qlp_if.c0Rx.wrValid = 1'b1;
    qlp_if.c1Rx.wrValid = 1'b1;
    tick();
    tick();
    qlp_if.c0Rx.wrValid = 1'b0;
    qlp_if.c1Rx.wrValid = 1'b0;
    check_eq("wr_zero", wr_inflight_o, 0);
    check_eq("no_unf_yet", err_underflow_o, 0);

    // underflow
    rsp_rd(1);
    check_eq("unf_rd_held", rd_inflight_o, 0);
    check_eq("unf_flag", err_underflow_o, 1);
    check_eq("unf_no_ovf", err_overflow_o, 0);

    // overflow
    issue_rd(128);
    check_eq("rd_128", rd_inflight_o, 128);
    check_eq("ovf_not_yet", err_overflow_o, 0);
    issue_rd(1);
    check_eq("ovf_rd_held", rd_inflight_o, 128);
    check_eq("ovf_flag", err_overflow_o, 1);
    rsp_rd(128);
    check_eq("rd_after_ovf", rd_inflight_o, 0);
    check_eq("stat_rd_254", stat_rd_reqs_o, 254);
    check_eq("peak_128", stat_rd_peak_o, 128);
    check_eq("unf_sticky", err_underflow_o, 1);

    // drain with traffic outstanding
    for (int i = 0; i < 10; i++) begin
      afu_if.c0TxRdValid = 1'b1;
      afu_if.c1TxWrValid = (i < 3);
      tick();
    end
    afu_if.c0TxRdValid = 1'b0;
    afu_if.c1TxWrValid = 1'b0;
    check_eq("drain_rd_10", rd_inflight_o, 10);
    check_eq("drain_wr_3", wr_inflight_o, 3);
    drain_req_i = 1'b1;
    tick();
    check_eq("drain_c0_af", afu_if.c0TxAlmFull, 1);
    check_eq("drain_c1_af", afu_if.c1TxAlmFull, 1);
    check_eq("drain_not_done", drain_done_o, 0);
    for (int i = 0; i < 10; i++) begin
      qlp_if.c0Rx.rdValid = 1'b1;
      qlp_if.c1Rx.wrValid = (i < 3);
      tick();
    end
    qlp_if.c0Rx.rdValid = 1'b0;
    qlp_if.c1Rx.wrValid = 1'b0;
    check_eq("drain_cnt_zero", rd_inflight_o + wr_inflight_o, 0);
    check_eq("drain_done_lag", drain_done_o, 0);
    tick();
    check_eq("drain_done", drain_done_o, 1);
    drain_req_i = 1'b0;
    tick();
    check_eq("drain_release", drain_done_o, 0);
    check_eq("drain_af_release", afu_if.c0TxAlmFull, 0);

    // drain with nothing outstanding
    drain_req_i = 1'b1;
    tick();
    check_eq("zdrain_draining", drain_done_o, 0);
    check_eq("zdrain_af", afu_if.c1TxAlmFull, 1);
    tick();
    check_eq("zdrain_done", drain_done_o, 1);
    drain_req_i = 1'b0;
    tick();

    // QLP-side reset does not clear counts
    issue_rd(2);
    qlp_if.reset_n = 1'b0;
    #1;
    check_eq("qlp_rst_pass", afu_if.reset_n, 0);
    tick();
    check_eq("qlp_rst_keeps", rd_inflight_o, 2);
    qlp_if.reset_n = 1'b1;

    // drain aborted while draining
    drain_req_i = 1'b1;
    tick();
    check_eq("abort_af_forced", afu_if.c0TxAlmFull, 1);
    drain_req_i = 1'b0;
    tick();
    check_eq("abort_idle_af", afu_if.c0TxAlmFull, 0);
    check_eq("abort_done", drain_done_o, 0);

    // async reset mid-burst
    afu_if.c0TxRdValid = 1'b1;
    tick();
    tick();
    check_eq("burst_rd_4", rd_inflight_o, 4);
    #2 reset_n_i = 1'b0;
    #1;
    check_eq("arst_rd", rd_inflight_o, 0);
    check_eq("arst_ovf", err_overflow_o, 0);
    check_eq("arst_unf", err_underflow_o, 0);
    check_eq("arst_stat_rd", stat_rd_reqs_o, 0);
    check_eq("arst_peak", stat_rd_peak_o, 0);
    afu_if.c0TxRdValid = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    tick();
    check_eq("post_rst_rd", rd_inflight_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
